// File: rtl/led_pkg.sv
// led_pkg: mode encoding and shared constants for the LED pattern generator.
package led_pkg;
    typedef logic [1:0] led_mode_t;
    localparam led_mode_t LED_OFF   = 2'b00;
    localparam led_mode_t LED_ON    = 2'b01;
    localparam led_mode_t LED_BLINK = 2'b10;
    localparam led_mode_t LED_PWM   = 2'b11;
    localparam int PERIOD_MIN = 2;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with shadow/active config, period counter and registered output.
// Ports: clk/rst_n clock and async active-low reset; i_we/i_mode/i_period/i_duty shadow write;
//        i_phase shared PWM phase; o_pending shadow waiting; o_led registered drive.
// Optional: LED_BREATHE_EN makes PWM mode with a nonzero period ramp its duty as a triangle.
module led_channel
    import led_pkg::*;
#(
    parameter int               CNT_W          = 32,
    parameter int               PWM_W          = 8,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_period,
    input  logic [PWM_W-1:0] i_duty,
    input  logic [PWM_W-1:0] i_phase,
    output logic             o_pending,
    output logic             o_led
);
    led_mode_t        r_sh_mode, r_act_mode;
    logic [CNT_W-1:0] r_sh_period, r_act_period, r_cnt;
    logic [PWM_W-1:0] r_sh_duty, r_act_duty;
    logic             r_pending, r_led;
    logic [CNT_W-1:0] w_period;
    logic             w_count, w_wrap, w_xfer, w_led;

    assign w_period = (i_period < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : i_period;
`ifdef LED_BREATHE_EN
    logic             r_sh_pnz, r_act_pnz, r_dir;
    logic             w_dir_next;
    logic [PWM_W-1:0] w_duty_step;
    // the zero-period test uses the raw written value, before the clamp
    assign w_count     = (r_act_mode == LED_BLINK) || (r_act_mode == LED_PWM && r_act_pnz);
    // reverse at the rails so the step moves away from them in the same cycle
    assign w_dir_next  = r_dir ? (r_act_duty != '1) : (r_act_duty == '0);
    assign w_duty_step = w_dir_next ? r_act_duty + 1'b1 : r_act_duty - 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_pnz  <= 1'b1;
            r_act_pnz <= 1'b1;
            r_dir     <= 1'b1;
        end else begin
            if (i_we)
                r_sh_pnz <= |i_period;
            if (w_xfer) begin
                r_act_pnz <= r_sh_pnz;
                r_dir     <= 1'b1;
            end else if (w_wrap && r_act_mode == LED_PWM) begin
                r_dir <= w_dir_next;
            end
        end
    end
`else
    assign w_count = (r_act_mode == LED_BLINK);
`endif
    assign w_wrap = w_count && (r_cnt == r_act_period - 1'b1);
    // non-counting modes have no phase to protect, so they take new config at once
    assign w_xfer = r_pending && (!w_count || w_wrap);
    assign w_led  = (r_act_mode == LED_ON)
                 || (r_act_mode == LED_BLINK && r_cnt < (r_act_period >> 1))
                 || (r_act_mode == LED_PWM && i_phase < r_act_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_mode    <= LED_OFF;
            r_act_mode   <= LED_OFF;
            r_sh_period  <= DEFAULT_PERIOD;
            r_act_period <= DEFAULT_PERIOD;
            r_sh_duty    <= '0;
            r_act_duty   <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            if (i_we) begin
                r_sh_mode   <= i_mode;
                r_sh_period <= w_period;
                r_sh_duty   <= i_duty;
            end
            r_pending <= i_we || (r_pending && !w_xfer);
            if (w_xfer) begin
                r_act_mode   <= r_sh_mode;
                r_act_period <= r_sh_period;
                r_act_duty   <= r_sh_duty;
                r_cnt        <= '0;
            end else begin
                r_cnt <= (w_count && !w_wrap) ? r_cnt + 1'b1 : '0;
`ifdef LED_BREATHE_EN
                if (w_wrap && r_act_mode == LED_PWM)
                    r_act_duty <= w_duty_step;
`endif
            end
            r_led <= w_led;
        end
    end

    assign o_pending = r_pending;
    assign o_led     = r_led;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver (off/on/blink/PWM) with glitch-free config update.
// Ports: sys_clk/sys_rst_n clock and async active-low reset; cfg_we/cfg_sel/cfg_mode/cfg_period/
//        cfg_duty per-channel config write; cfg_pending shadow waiting per channel; led drive.
// Optional: LED_BREATHE_EN enables the breathing PWM ramp inside each channel.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int               NUM_LED        = 4,
    parameter int               CNT_W          = 32,
    parameter int               PWM_W          = 8,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 32'd50000000,
    localparam int              SEL_W          = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [PWM_W-1:0]   cfg_duty,
    output logic [NUM_LED-1:0] cfg_pending,
    output logic [NUM_LED-1:0] led
);
    logic [PWM_W-1:0] r_phase;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_phase <= '0;
        else
            r_phase <= r_phase + 1'b1;
    end

    // an out-of-range select matches no channel, so the write is dropped
    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        led_channel #(
            .CNT_W          (CNT_W),
            .PWM_W          (PWM_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (sys_clk),
            .rst_n     (sys_rst_n),
            .i_we      (cfg_we && cfg_sel == SEL_W'(i)),
            .i_mode    (cfg_mode),
            .i_period  (cfg_period),
            .i_duty    (cfg_duty),
            .i_phase   (r_phase),
            .o_pending (cfg_pending[i]),
            .o_led     (led[i])
        );
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen (3 channels, 8-bit PWM).
module tb_led_pattern_gen;
    import led_pkg::*;

    logic        sys_clk, sys_rst_n, cfg_we;
    logic [1:0]  cfg_sel, cfg_mode;
    logic [31:0] cfg_period;
    logic [7:0]  cfg_duty;
    logic [2:0]  cfg_pending, led;
    int          n_checks, n_errors;
    logic [31:0] v, vp, acc;
    int          n;

    led_pattern_gen #(
        .NUM_LED        (3),
        .CNT_W          (32),
        .PWM_W          (8),
        .DEFAULT_PERIOD (32'd50000000)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_mode    (cfg_mode),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_pending (cfg_pending),
        .led         (led)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [1:0] mode,
                             input logic [31:0] period, input logic [7:0] duty);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_mode = mode;
        cfg_period = period;
        cfg_duty = duty;
        @(negedge sys_clk);
        cfg_we = 1'b0;
    endtask

    task automatic capture(input int ch, input int len, output logic [31:0] vec);
        vec = '0;
        for (int k = 0; k < len; k++) begin
            @(negedge sys_clk);
            vec[k] = led[ch];
        end
    endtask

    task automatic wait_clear(input int ch, input string tag);
        int k;
        k = 0;
        while (cfg_pending[ch] && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        check(tag, 32'(cfg_pending[ch]), 32'd0);
    endtask

    task automatic pwm_count(output int cnt);
        cnt = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        repeat (256) begin
            @(negedge sys_clk);
            cnt += int'(led[2]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sys_rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_sel = '0;
        cfg_mode = '0;
        cfg_period = '0;
        cfg_duty = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_pend", 32'(cfg_pending), 32'd0);
        sys_rst_n = 1'b1;
        acc = '0;
        repeat (200) begin
            @(negedge sys_clk);
            acc |= 32'({led, cfg_pending});
        end
        check("idle200", acc, 32'd0);

        cfg_write(2'd0, LED_BLINK, 32'd10, 8'd0);
        check("b10_pend_set", 32'(cfg_pending[0]), 32'd1);
        @(negedge sys_clk);
        check("b10_pend_clr", 32'(cfg_pending[0]), 32'd0);
        capture(0, 20, v);
        check("blink10", v, 32'h0007C1F);

        cfg_write(2'd1, LED_BLINK, 32'd7, 8'd0);
        check("b7_pend_set", 32'(cfg_pending[1]), 32'd1);
        @(negedge sys_clk);
        check("b7_pend_clr", 32'(cfg_pending[1]), 32'd0);
        capture(1, 14, v);
        check("blink7", v, 32'h387);
        repeat (2) @(negedge sys_clk);
        cfg_write(2'd1, LED_BLINK, 32'd4, 8'd0);
        check("b4_pend_set", 32'(cfg_pending[1]), 32'd1);
        v = '0;
        vp = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            v[k] = led[1];
            vp[k] = cfg_pending[1];
        end
        check("b7to4_led", v, 32'h330);
        check("b7to4_pend", vp, 32'h007);

        cfg_write(2'd2, LED_PWM, 32'd0, 8'd64);
        pwm_count(n);
        check("pwm64", 32'(n), 32'd64);
        cfg_write(2'd2, LED_PWM, 32'd0, 8'd255);
        pwm_count(n);
        check("pwm255", 32'(n), 32'd255);
        cfg_write(2'd2, LED_PWM, 32'd0, 8'd0);
        pwm_count(n);
        check("pwm0", 32'(n), 32'd0);

        cfg_write(2'd1, LED_BLINK, 32'd0, 8'd0);
        wait_clear(1, "clamp0_xfer");
        capture(1, 8, v);
        check("clamp0", v, 32'h55);
        cfg_write(2'd1, LED_BLINK, 32'd1, 8'd0);
        wait_clear(1, "clamp1_xfer");
        capture(1, 8, v);
        check("clamp1", v, 32'h55);

        cfg_write(2'd3, LED_ON, 32'd10, 8'd255);
        check("badsel_pend", 32'(cfg_pending), 32'd0);
        capture(2, 8, v);
        check("badsel_led", v, 32'd0);

        cfg_write(2'd2, LED_ON, 32'd10, 8'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("on_led", 32'(led[2]), 32'd1);
        cfg_write(2'd1, LED_BLINK, 32'd100, 8'd0);
        check("pre_rst_pend", 32'(cfg_pending[1]), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 32'd0);
        check("async_pend", 32'(cfg_pending), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        acc = '0;
        repeat (20) begin
            @(negedge sys_clk);
            acc |= 32'({led, cfg_pending});
        end
        check("post_rst", acc, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
